mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multiply/divide unit in the E stage of the P7 pipeline. It accepts mult/multu/div/divu issued from E and holds the HI/LO architectural registers. It emulates the fixed latency of a real multiplier/divider by asserting `Busy`. Together with the issuing `Start`, `Busy` drives the hazard unit's MD stall of D-stage HI/LO instructions. It also serves mfhi/mflo reads and mthi/mtlo writes, and suppresses side effects when an exception/interrupt request is being taken.

## Interface
- `MULT_CYCLES`, default 5: Busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: Busy cycles for div/divu.
- `clk`  in  1  system clock. Single clock domain; everything samples on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `Start`  in  1  E-stage instruction is mult/multu/div/divu this cycle.
- `MDOp`  in  4  operation select. Encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- `A`  in  32  forwarded rs value (E stage).
- `B`  in  32  forwarded rt value (E stage).
- `Req`  in  1  exception/interrupt being taken this cycle; the E instruction must have no effect.
- `Busy`  out  1  operation in flight.
- `HI`  out  32  current HI register.
- `LO`  out  32  current LO register.
- `MDOut`  out  32  read data for mfhi/mflo, combinational.

## Operation
- States: IDLE and BUSY. A counter `cnt` of width $clog2(DIV_CYCLES+1) tracks the remaining cycles.
- IDLE, `Start`=1, `Req`=0, MDOp in 1..4:
  - Compute the result from `A`/`B` this cycle and latch it into `hi_pend`/`lo_pend`.
  - Load `cnt` with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4). Go to BUSY.
- Arithmetic:
  - mult: signed 32×32→64, HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - divu: same, unsigned.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B = 0): the full DIV_CYCLES Busy period still runs; HI/LO are not written at completion.
- BUSY: `cnt` decrements each edge. On the edge where `cnt`==1, HI/LO take the pending values (unless divide by zero) and the state returns to IDLE.
- `Start` while BUSY: ignored. The hazard unit guarantees it never occurs; the bench checks that it is ignored.
- `Req`=1 while BUSY: the in-flight operation belongs to an older instruction and completes normally.
- `Req`=1 in IDLE: `Start`, mthi and mtlo are all suppressed. No state change.
- mthi/mtlo (MDOp 7/8), `Req`=0, IDLE: HI or LO ← `A` at the edge. Ignored while BUSY.
- `MDOut`: HI when MDOp=5, LO when MDOp=6, else 0.
- `Busy` is a registered output. It equals (state == BUSY).

## Timing
- Reset (async, immediate): state IDLE, `cnt`=0, `Busy`=0, `HI`=0, `LO`=0, pending registers 0. `MDOut` follows (0).
- `Start` sampled at edge t: `Busy`=1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
- The new HI/LO become visible in cycle t+N+1, the same cycle `Busy` falls.
- Back-to-back: a new `Start` is accepted in the first cycle `Busy`=0.
- mthi/mtlo at edge t: `HI`/`LO` are visible in cycle t+1.
- An mfhi issued in the cycle after an mthi returns the new value.
- Reset asserted mid-BUSY: `Busy` drops and HI/LO clear without waiting for an edge. No pending write survives reset.

## Structure
- MDOp encodings go in the shared header `head.v` as `define constants (`MD_NONE` … `MD_MTLO`), alongside the existing funct constants.
- The cycle parameters stay local to this module.
- Single module with no sub-module. The datapath is combinational multiply/divide feeding the pending registers. The state machine and counter are inline.

## Test plan
- mult A=0xFFFFFFFF, B=2 → `Busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → `Busy` 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0, then div B=0 → 10 Busy cycles, HI/LO still 0x12345678/0x9ABCDEF0. mfhi/mflo `MDOut` matches.
- `Start` (mult 3×4) with `Req`=1 → `Busy` stays 0, HI/LO unchanged. mtlo with `Req`=1 → LO unchanged.
- mult 3×4 started; during Busy cycle 2 assert `Start` (divu 9/3) and `Req`=1 → ignored, mult completes, LO=12, HI=0.
- mult started; assert `reset` between edges in Busy cycle 3 → `Busy`=0, HI=LO=0 immediately. After release, no HI/LO write occurs.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared MDOp encodings and state type for the E-stage multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multiply/divide unit holding HI/LO; results are computed at issue and committed
// after a fixed Busy period that models real multiplier/divider latency.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_e     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   hi_pend_reg, hi_pend_next;
  logic [31:0]   lo_pend_reg, lo_pend_next;
  logic          dz_reg, dz_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, a_mag, b_mag, q_mag, r_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  // Sign-extending to 64 bits makes the low 64 bits of the product the signed result.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // A zero divisor never commits, so substitute 1 to keep the divider defined.
  assign b_safe = (B == 32'd0) ? 32'd1 : B;

  // Signed divide on magnitudes; 0x80000000 has magnitude 0x80000000 unsigned, so
  // the most-negative / -1 case naturally yields 0x80000000 with remainder 0.
  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = b_safe[31] ? (32'd0 - b_safe) : b_safe;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quo_s = (A[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
  assign rem_s = A[31] ? (32'd0 - r_mag) : r_mag;
  assign quo_u = A / b_safe;
  assign rem_u = A % b_safe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      hi_pend_reg <= '0;
      lo_pend_reg <= '0;
      dz_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      hi_pend_reg <= hi_pend_next;
      lo_pend_reg <= lo_pend_next;
      dz_reg      <= dz_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    hi_pend_next = hi_pend_reg;
    lo_pend_next = lo_pend_reg;
    dz_next      = dz_reg;
    case (state_reg)
      ST_IDLE: begin
        // A taken exception/interrupt squashes every side effect of the E instruction.
        if (!Req) begin
          if (Start && is_arith(MDOp)) begin
            case (MDOp)
              MD_MULT: begin
                hi_pend_next = prod_s[63:32];
                lo_pend_next = prod_s[31:0];
              end
              MD_MULTU: begin
                hi_pend_next = prod_u[63:32];
                lo_pend_next = prod_u[31:0];
              end
              MD_DIV: begin
                hi_pend_next = rem_s;
                lo_pend_next = quo_s;
              end
              default: begin
                hi_pend_next = rem_u;
                lo_pend_next = quo_u;
              end
            endcase
            dz_next    = !is_mul(MDOp) && (B == 32'd0);
            cnt_next   = is_mul(MDOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_next = ST_BUSY;
          end else if (MDOp == MD_MTHI) begin
            hi_next = A;
          end else if (MDOp == MD_MTLO) begin
            lo_next = A;
          end
        end
      end
      ST_BUSY: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = ST_IDLE;
          if (!dz_reg) begin
            hi_next = hi_pend_reg;
            lo_next = lo_pend_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign Busy = (state_reg == ST_BUSY);
  assign HI   = hi_reg;
  assign LO   = lo_reg;

  always_comb begin
    MDOut = 32'd0;
    if (MDOp == MD_MFHI) MDOut = hi_reg;
    else if (MDOp == MD_MFLO) MDOut = lo_reg;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: spec vector table, hand-written corner
// sequences, then random operations against a plain-arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Req = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  int tests = 0;
  int fails = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Reference model: architectural results from 64-bit integer arithmetic.
  function automatic void ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output int n);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = hi_m;
    lo = lo_m;
    n  = (op == MD_MULT || op == MD_MULTU) ? MC : DC;
    case (op)
      MD_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      MD_MULTU: begin pu = ua * ub; hi = pu[63:32]; lo = pu[31:0]; end
      MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      default:  if (b != 0) begin qu = ua / ub; ru = ua % ub; hi = ru[31:0]; lo = qu[31:0]; end
    endcase
  endfunction

  // Presents one E-stage instruction for exactly one rising edge; returns at edge+1.
  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    @(negedge clk);
    Start = s; MDOp = op; A = a; B = b; Req = r;
    @(posedge clk);
    #1;
    Start = 1'b0; MDOp = MD_NONE; Req = 1'b0;
  endtask

  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int en);
    int n;
    drive(1'b1, op, a, b, 1'b0);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      if (n == 1) check32({name, " hi held while busy"}, HI, hi_m);
      @(posedge clk);
      #1;
    end
    check32({name, " busy cycles"}, n, en);
    check32({name, " HI"}, HI, ehi);
    check32({name, " LO"}, LO, elo);
    hi_m = ehi;
    lo_m = elo;
  endtask

  vec_t vecs[5];

  initial begin
    logic [31:0] ehi, elo, ra, rb;
    logic [3:0]  op;
    int          en, n;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        DC};
    vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};

    repeat (3) @(posedge clk);
    #1;
    check32("reset Busy", {31'd0, Busy}, 32'd0);
    check32("reset HI", HI, 32'd0);
    check32("reset LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    MDOp = MD_MFHI;
    #1;
    check32("reset MDOut", MDOut, 32'd0);
    MDOp = MD_NONE;

    foreach (vecs[i])
      run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n);

    // mthi/mtlo, immediate mfhi, then divide by zero leaves HI/LO alone
    drive(1'b0, MD_MTHI, 32'h12345678, 32'd0, 1'b0);
    MDOp = MD_MFHI;
    #1;
    check32("mfhi after mthi", MDOut, 32'h12345678);
    MDOp = MD_NONE;
    drive(1'b0, MD_MTLO, 32'h9ABCDEF0, 32'd0, 1'b0);
    check32("mtlo LO", LO, 32'h9ABCDEF0);
    hi_m = 32'h12345678;
    lo_m = 32'h9ABCDEF0;
    run_md("div by zero", MD_DIV, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, DC);
    MDOp = MD_MFLO;
    #1;
    check32("mflo after dz", MDOut, 32'h9ABCDEF0);
    MDOp = MD_NONE;

    // Req in IDLE suppresses Start and mtlo
    drive(1'b1, MD_MULT, 32'd3, 32'd4, 1'b1);
    check32("req start Busy", {31'd0, Busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check32("req start HI", HI, hi_m);
    check32("req start LO", LO, lo_m);
    drive(1'b0, MD_MTLO, 32'hDEADBEEF, 32'd0, 1'b1);
    check32("req mtlo LO", LO, lo_m);

    // Start+Req while busy is ignored; the in-flight mult completes
    drive(1'b1, MD_MULT, 32'd3, 32'd4, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, MD_DIVU, 32'd9, 32'd3, 1'b1);
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    check32("busy start remaining cycles", n, 3);
    check32("busy start HI", HI, 32'd0);
    check32("busy start LO", LO, 32'd12);
    @(posedge clk);
    #1;
    check32("busy start no 2nd op", {31'd0, Busy}, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd12;

    // Async reset during Busy cycle 3
    drive(1'b0, MD_MTHI, 32'hAAAA5555, 32'd0, 1'b0);
    drive(1'b1, MD_MULT, 32'd5, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check32("async rst Busy", {31'd0, Busy}, 32'd0);
    check32("async rst HI", HI, 32'd0);
    check32("async rst LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check32("post rst Busy", {31'd0, Busy}, 32'd0);
    check32("post rst HI", HI, 32'd0);
    check32("post rst LO", LO, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;

    // Random mix against the reference model
    for (int k = 0; k < 30; k++) begin
      op = 4'($urandom_range(1, 8));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (op == MD_MFHI || op == MD_MFLO) begin
        @(negedge clk);
        MDOp = op;
        #1;
        check32($sformatf("rnd%0d mf op%0d", k, op), MDOut, (op == MD_MFHI) ? hi_m : lo_m);
        MDOp = MD_NONE;
      end else if (op == MD_MTHI || op == MD_MTLO) begin
        drive(1'b0, op, ra, 32'd0, 1'b0);
        if (op == MD_MTHI) hi_m = ra; else lo_m = ra;
        check32($sformatf("rnd%0d mt HI", k), HI, hi_m);
        check32($sformatf("rnd%0d mt LO", k), LO, lo_m);
      end else begin
        ref_md(op, ra, rb, ehi, elo, en);
        run_md($sformatf("rnd%0d op%0d %08h %08h", k, op, ra, rb), op, ra, rb, ehi, elo, en);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
